// File: rtl/bayer_mosaic.sv
// Re-mosaics a raster RGB stream into an 8-bit Bayer raw stream with frame/line markers.
// Two register stages: input/tag capture, then channel select and marker output.
module bayer_mosaic #(
  parameter int unsigned width  = 320,
  parameter int unsigned height = 240,
  parameter int unsigned PHASE  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iValid,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  input  logic       iSof,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oSof,
  output logic       oEol,
  output logic       oEof,
  output logic       oErr
);

  localparam int unsigned XW = $clog2(width);
  localparam int unsigned YW = $clog2(height);
  localparam logic [XW-1:0] XLast = XW'(width - 1);
  localparam logic [YW-1:0] YLast = YW'(height - 1);
  localparam logic [1:0] Ph = 2'(PHASE);

  logic [XW-1:0] x_q, x_d, px;
  logic [YW-1:0] y_q, y_d, py;
  logic          err_q, err_d;
  logic          resync;

  logic [7:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic       v1_q, v1_d;
  logic [1:0] par1_q, par1_d;
  logic       sof1_q, sof1_d, eol1_q, eol1_d, eof1_q, eof1_d;

  logic [7:0] data_q, data_d;
  logic       v2_q, v2_d, sof2_q, sof2_d, eol2_q, eol2_d, eof2_q, eof2_d;

  always_comb begin
    // A mid-frame iSof restarts the frame: this pixel becomes (0,0).
    resync = iValid && iSof && !((x_q == '0) && (y_q == '0));
    px     = resync ? '0 : x_q;
    py     = resync ? '0 : y_q;
    x_d    = x_q;
    y_d    = y_q;
    err_d  = err_q | resync;
    if (iValid) begin
      if (px == XLast) begin
        x_d = '0;
        y_d = (py == YLast) ? '0 : py + YW'(1);
      end else begin
        x_d = px + XW'(1);
        y_d = py;
      end
    end

    v1_d   = iValid;
    r1_d   = iValid ? iR : r1_q;
    g1_d   = iValid ? iG : g1_q;
    b1_d   = iValid ? iB : b1_q;
    par1_d = {py[0], px[0]} ^ Ph;
    sof1_d = iValid && (px == '0) && (py == '0);
    eol1_d = iValid && (px == XLast);
    eof1_d = iValid && (px == XLast) && (py == YLast);

    data_d = data_q;
    if (v1_q) begin
      unique case (par1_q)
        2'b00:   data_d = r1_q;
        2'b11:   data_d = b1_q;
        default: data_d = g1_q;
      endcase
    end
    v2_d   = v1_q;
    sof2_d = v1_q && sof1_q;
    eol2_d = v1_q && eol1_q;
    eof2_d = v1_q && eof1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      err_q  <= 1'b0;
      r1_q   <= '0;
      g1_q   <= '0;
      b1_q   <= '0;
      v1_q   <= 1'b0;
      par1_q <= '0;
      sof1_q <= 1'b0;
      eol1_q <= 1'b0;
      eof1_q <= 1'b0;
      data_q <= '0;
      v2_q   <= 1'b0;
      sof2_q <= 1'b0;
      eol2_q <= 1'b0;
      eof2_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      err_q  <= err_d;
      r1_q   <= r1_d;
      g1_q   <= g1_d;
      b1_q   <= b1_d;
      v1_q   <= v1_d;
      par1_q <= par1_d;
      sof1_q <= sof1_d;
      eol1_q <= eol1_d;
      eof1_q <= eof1_d;
      data_q <= data_d;
      v2_q   <= v2_d;
      sof2_q <= sof2_d;
      eol2_q <= eol2_d;
      eof2_q <= eof2_d;
    end
  end

  assign oData  = data_q;
  assign oValid = v2_q;
  assign oSof   = sof2_q;
  assign oEol   = eol2_q;
  assign oEof   = eof2_q;
  assign oErr   = err_q;

endmodule

// File: tb/tb_bayer_mosaic.sv
// Drives one 4x2 stream into four instances (PHASE 0..3) and scoreboards every output cycle.
module tb_bayer_mosaic;

  localparam int W = 4;
  localparam int H = 2;

  typedef struct packed {
    logic       v;
    logic [7:0] r, g, b;
    logic [1:0] par;
    logic       sof, eol, eof;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_valid = 1'b0, i_sof = 1'b0;
  logic [7:0] i_r = '0, i_g = '0, i_b = '0;
  logic [7:0] o_data [4];
  logic       o_valid [4], o_sof [4], o_eol [4], o_eof [4], o_err [4];

  exp_t       exp_q[$];
  logic [7:0] last_d [4];
  int         mx, my;
  logic       err_m;
  int         n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    bayer_mosaic #(.width(W), .height(H), .PHASE(p)) u_dut (
      .clk(clk), .reset(reset), .iValid(i_valid), .iR(i_r), .iG(i_g), .iB(i_b), .iSof(i_sof),
      .oData(o_data[p]), .oValid(o_valid[p]), .oSof(o_sof[p]), .oEol(o_eol[p]),
      .oEof(o_eof[p]), .oErr(o_err[p])
    );
  end

  task automatic chk(input string tag, input int ph, input logic [7:0] obs, input logic [7:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s phase%0d: got %0d expected %0d", tag, ph, obs, req);
    end
  endtask

  function automatic logic [7:0] cfa(input int ph, input exp_t e);
    logic [1:0] p;
    p = e.par ^ 2'(ph);
    if (p == 2'b00) return e.r;
    if (p == 2'b11) return e.b;
    return e.g;
  endfunction

  task automatic model_init();
    exp_q.delete();
    for (int k = 0; k < 2; k++) exp_q.push_back('0);
    for (int p = 0; p < 4; p++) last_d[p] = '0;
    mx = 0;
    my = 0;
    err_m = 1'b0;
  endtask

  task automatic check_all();
    exp_t       e;
    logic [7:0] d;
    e = exp_q.pop_front();
    for (int p = 0; p < 4; p++) begin
      d = e.v ? cfa(p, e) : last_d[p];
      last_d[p] = d;
      chk("data", p, o_data[p], d);
      chk("valid", p, 8'(o_valid[p]), 8'(e.v));
      chk("sof", p, 8'(o_sof[p]), 8'(e.sof));
      chk("eol", p, 8'(o_eol[p]), 8'(e.eol));
      chk("eof", p, 8'(o_eof[p]), 8'(e.eof));
      chk("err", p, 8'(o_err[p]), 8'(err_m));
    end
  endtask

  task automatic step(input logic v, input logic [7:0] r, g, b, input logic s);
    exp_t e;
    int   px, py;
    @(negedge clk);
    check_all();
    i_valid = v; i_r = r; i_g = g; i_b = b; i_sof = s;
    e = '0;
    if (v) begin
      if (s && !(mx == 0 && my == 0)) begin
        px = 0; py = 0; err_m = 1'b1;
      end else begin
        px = mx; py = my;
      end
      if (px == W - 1) begin
        mx = 0;
        my = (py == H - 1) ? 0 : py + 1;
      end else begin
        mx = px + 1;
        my = py;
      end
      e.v = 1'b1; e.r = r; e.g = g; e.b = b;
      e.par = {py[0], px[0]};
      e.sof = (px == 0) && (py == 0);
      e.eol = (px == W - 1);
      e.eof = (px == W - 1) && (py == H - 1);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic rnd_pix(input logic s);
    step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), s);
  endtask

  initial begin
    model_init();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Constant colours, all four phases at once; second frame without iSof.
    for (int i = 0; i < W * H; i++) step(1'b1, 8'd10, 8'd20, 8'd30, i == 0);
    for (int i = 0; i < W * H; i++) rnd_pix(1'b0);

    // Random idle gaps (~40%).
    for (int i = 0; i < 2 * W * H; i++) begin
      while ($urandom_range(0, 9) < 4) idle();
      rnd_pix(i == 0);
    end

    // Mid-frame resync at (2,1), then a full clean frame.
    for (int i = 0; i < W + 2; i++) rnd_pix(1'b0);
    rnd_pix(1'b1);
    for (int i = 0; i < W * H + 2; i++) rnd_pix(1'b0);
    idle();

    // Asynchronous reset between edges mid-line.
    rnd_pix(1'b0);
    #2 reset = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      chk("rst_data", p, o_data[p], 8'd0);
      chk("rst_flags", p, {3'b0, o_valid[p], o_sof[p], o_eol[p], o_eof[p], o_err[p]}, 8'd0);
    end
    i_valid = 1'b0;
    i_sof = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_init();
    for (int i = 0; i < W * H; i++) rnd_pix(1'b0);
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
